frame_config_loader: RTL



---
 rtl/frame_config_loader_pkg.sv | 23 ++
 rtl/frame_config_loader_strobe_decoder.sv | 27 ++
 rtl/frame_config_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/frame_config_loader_pkg.sv
// rtl/frame_config_loader_pkg.sv - shared states, stream keywords and header field positions
package frame_config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_STROBE = 3'd4
    } state_e;

    localparam logic [31:0] SYNC_WORD_DEFAULT   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD_DEFAULT = 32'hFAB0_FAB0;

    localparam int COL_MSB   = 31;
    localparam int COL_LSB   = 24;
    localparam int FRAME_MSB = 20;
    localparam int FRAME_LSB = 16;

    localparam int COL_W   = COL_MSB - COL_LSB + 1;
    localparam int FRAME_W = FRAME_MSB - FRAME_LSB + 1;

endpackage

// File: rtl/frame_config_loader_strobe_decoder.sv
// rtl/frame_config_loader_strobe_decoder.sv - column/frame address to one-hot strobe vector
module frame_strobe_decoder
    import frame_config_loader_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumCols         = 1
) (
    input  logic [COL_W-1:0]                   col_i,
    input  logic [FRAME_W-1:0]                 frame_i,
    output logic [NumCols*MaxFramesPerCol-1:0] onehot_o,
    output logic                               valid_o
);

    logic [31:0] bit_idx;

    assign valid_o = (32'(col_i) < 32'(NumCols)) && (32'(frame_i) < 32'(MaxFramesPerCol));
    assign bit_idx = 32'(col_i) * 32'(MaxFramesPerCol) + 32'(frame_i);

    // Out-of-range addresses decode to all zeros rather than aliasing another frame.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NumCols * MaxFramesPerCol; i++) begin
            onehot_o[i] = valid_o && (bit_idx == 32'(i));
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - bitstream word stream to per-row FrameData plus one FrameStrobe pulse
// Optional XOR check word after each frame when FRAME_CHECK_EN is defined.
module frame_config_loader
    import frame_config_loader_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumRows         = 2,
    parameter int          NumCols         = 1,
    parameter logic [31:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
    parameter logic [31:0] DESYNC_WORD     = DESYNC_WORD_DEFAULT
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic [31:0]                         s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                busy,
    output logic                                err,
    output logic [15:0]                         frames_done
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_e                               state_q;
    logic [NumRows*FrameBitsPerRow-1:0]   frame_data_q;
    logic [NumCols*MaxFramesPerCol-1:0]   frame_strobe_q;
    logic                                 err_q;
    logic [15:0]                          frames_done_q;
    logic [15:0]                          frames_done_d;
    logic [RowW-1:0]                      row_q;
    logic [COL_W-1:0]                     col_q;
    logic [FRAME_W-1:0]                   frame_q;

    logic                                 accept;
    logic                                 row_last;
    logic                                 enter_strobe;
    logic                                 strobe_ok;
    logic                                 addr_valid;
    logic [NumCols*MaxFramesPerCol-1:0]   addr_onehot;

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumCols         (NumCols)
    ) u_decoder (
        .col_i    (col_q),
        .frame_i  (frame_q),
        .onehot_o (addr_onehot),
        .valid_o  (addr_valid)
    );

    assign s_ready       = (state_q != ST_STROBE);
    assign accept        = s_valid && s_ready;
    assign row_last      = (row_q == RowW'(NumRows - 1));
    assign frames_done_d = frames_done_q + 16'd1;

`ifdef FRAME_CHECK_EN
    logic [FrameBitsPerRow-1:0] acc_q;

    assign enter_strobe = accept && (state_q == ST_CHECK);
    assign strobe_ok    = addr_valid && (s_data == acc_q);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (accept && state_q == ST_HEADER) begin
            acc_q <= '0;
        end else if (accept && state_q == ST_DATA) begin
            acc_q <= acc_q ^ s_data;
        end
    end
`else
    assign enter_strobe = accept && (state_q == ST_DATA) && row_last;
    assign strobe_ok    = addr_valid;
`endif

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            err_q          <= 1'b0;
            frames_done_q  <= '0;
            row_q          <= '0;
            col_q          <= '0;
            frame_q        <= '0;
        end else begin
            frame_strobe_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && s_data == SYNC_WORD) begin
                        state_q <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        if (s_data == DESYNC_WORD) begin
                            state_q <= ST_IDLE;
                        end else begin
                            col_q   <= s_data[COL_MSB:COL_LSB];
                            frame_q <= s_data[FRAME_MSB:FRAME_LSB];
                            row_q   <= '0;
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Rows load even for a bad header; only the strobe is withheld.
                    if (accept) begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (row_q == RowW'(r)) begin
                                frame_data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                            end
                        end
                        if (row_last) begin
`ifdef FRAME_CHECK_EN
                            state_q <= ST_CHECK;
`else
                            state_q <= ST_STROBE;
`endif
                        end else begin
                            row_q <= row_q + RowW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state_q <= ST_HEADER;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (enter_strobe) begin
                if (strobe_ok) begin
                    frame_strobe_q <= addr_onehot;
                    frames_done_q  <= frames_done_d;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;
    assign frames_done = frames_done_q;

endmodule
